regspace_apb_master: RTL and testbench

APB4 requester that turns a valid/ready command stream into single APB transfers. It is the requester-side counterpart of the generated APB register-space slaves, used by bring-up sequencers and DMA-style config engines to program register spaces. Transfers run one at a time: accept, SETUP, ACCESS until `p_ready` or timeout, then a held response beat. An ACCESS-phase timeout guards against hung slaves.

---
 rtl/regspace_apb_master_if.sv | 50 +++++
 rtl/regspace_apb_master.sv | 100 ++++++++++
 tb/tb_regspace_apb_master.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regspace_apb_master_if.sv
// Bundle of the command, APB and response signals of regspace_apb_master.
// The master modport is the requester's view; slave is the environment's view.
`timescale 1ns/1ps
interface regspace_apb_master_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_strb;
    logic [2:0]            req_prot;

    logic [ADDR_W-1:0]     p_addr;
    logic [2:0]            p_prot;
    logic                  p_sel;
    logic                  p_enable;
    logic                  p_write;
    logic [DATA_W-1:0]     p_wdata;
    logic [DATA_W/8-1:0]   p_strb;
    logic                  p_ready;
    logic [DATA_W-1:0]     p_rdata;
    logic                  p_slverr;

    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    modport master (
        input  req_vld, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  p_ready, p_rdata, p_slverr,
        input  rsp_rdy,
        output req_rdy,
        output p_addr, p_prot, p_sel, p_enable, p_write, p_wdata, p_strb,
        output rsp_vld, rsp_rdata, rsp_err, rsp_timeout
    );

    modport slave (
        output req_vld, req_write, req_addr, req_wdata, req_strb, req_prot,
        output p_ready, p_rdata, p_slverr,
        output rsp_rdy,
        input  req_rdy,
        input  p_addr, p_prot, p_sel, p_enable, p_write, p_wdata, p_strb,
        input  rsp_vld, rsp_rdata, rsp_err, rsp_timeout
    );
endinterface

// File: rtl/regspace_apb_master.sv
// APB4 requester: one command at a time through SETUP, ACCESS (with an
// optional hung-slave timeout) and a held response beat.
`timescale 1ns/1ps
module regspace_apb_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regspace_apb_master_if.master bus
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value seen in the last allowed ACCESS cycle without p_ready.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    assign bus.req_rdy = (state == IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset too, so an aborted transfer
        // leaves no stale address or data visible on the bus.
        if (!rst_n) begin
            state           <= IDLE;
            wait_cnt        <= '0;
            bus.p_addr      <= '0;
            bus.p_prot      <= '0;
            bus.p_sel       <= 1'b0;
            bus.p_enable    <= 1'b0;
            bus.p_write     <= 1'b0;
            bus.p_wdata     <= '0;
            bus.p_strb      <= '0;
            bus.rsp_vld     <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_vld) begin
                        bus.p_addr  <= bus.req_addr;
                        bus.p_prot  <= bus.req_prot;
                        bus.p_write <= bus.req_write;
                        bus.p_wdata <= bus.req_write ? bus.req_wdata : '0;
                        bus.p_strb  <= bus.req_write ? bus.req_strb  : '0;
                        bus.p_sel   <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    bus.p_enable <= 1'b1;
                    state        <= ACCESS;
                end
                ACCESS: begin
                    // A ready slave wins over a timeout expiring in the same cycle.
                    if (bus.p_ready) begin
                        bus.p_sel       <= 1'b0;
                        bus.p_enable    <= 1'b0;
                        bus.rsp_vld     <= 1'b1;
                        bus.rsp_rdata   <= bus.p_write ? '0 : bus.p_rdata;
                        bus.rsp_err     <= bus.p_slverr;
                        bus.rsp_timeout <= 1'b0;
                        state           <= RESP;
                    end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
                        bus.p_sel       <= 1'b0;
                        bus.p_enable    <= 1'b0;
                        bus.rsp_vld     <= 1'b1;
                        bus.rsp_rdata   <= '0;
                        bus.rsp_err     <= 1'b1;
                        bus.rsp_timeout <= 1'b1;
                        state           <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_rdy) begin
                        bus.rsp_vld <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regspace_apb_master.sv
// Self-checking bench for regspace_apb_master: directed scenarios plus random
// transfers, each checked cycle by cycle against a transfer-level model.
`timescale 1ns/1ps
module tb_regspace_apb_master;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    regspace_apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    regspace_apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // One transfer, observed each cycle from accept until back in IDLE.
    // Model: slave holds p_ready low for 'waits' ACCESS cycles; if that reaches
    // TO the transfer times out after exactly TO ACCESS cycles.
    task automatic do_txn(input string name, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                          input logic [2:0] prot, input int waits, input logic slverr,
                          input logic [DW-1:0] rdata, input int bp);
        int                          len;
        int                          last;
        logic                        tmo;
        logic [DW-1:0]               exp_rdata;
        logic                        exp_err;
        logic [AW+1+DW+SW+3-1:0]     exp_req;
        logic [AW+1+DW+SW+3-1:0]     obs_req;
        logic [3:0]                  exp_ctl;
        logic [3:0]                  obs_ctl;
        logic [DW+1:0]               exp_rsp;
        logic [DW+1:0]               obs_rsp;
        logic                        rdy;

        tmo       = (waits >= TO);
        len       = tmo ? TO : waits + 1;
        last      = 2 + len + bp + 1;
        exp_rdata = (tmo || wr) ? '0 : rdata;
        exp_err   = tmo | slverr;
        exp_req   = {addr, wr, wr ? wdata : {DW{1'b0}}, wr ? strb : {SW{1'b0}}, prot};
        exp_rsp   = {exp_rdata, exp_err, tmo};

        n_cmp++;
        if (bus.req_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s pre-accept req_rdy got %b want 1", name, bus.req_rdy);
        end

        bus.req_vld   = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_strb  = strb;
        bus.req_prot  = prot;
        @(posedge clk); #1;
        // Scramble the command inputs so any late capture shows up on p_*.
        bus.req_vld   = 1'b0;
        bus.req_write = 1'($urandom);
        bus.req_addr  = AW'($urandom);
        bus.req_wdata = DW'($urandom);
        bus.req_strb  = SW'($urandom);
        bus.req_prot  = 3'($urandom);

        for (int c = 1; c <= last; c++) begin
            if (c == 1)                 exp_ctl = 4'b1000;
            else if (c <= 1 + len)      exp_ctl = 4'b1100;
            else if (c <= 2 + len + bp) exp_ctl = 4'b0010;
            else                        exp_ctl = 4'b0001;

            obs_ctl = {bus.p_sel, bus.p_enable, bus.rsp_vld, bus.req_rdy};
            n_cmp++;
            if (obs_ctl !== exp_ctl) begin
                n_bad++;
                $display("FAIL %s cyc%0d ctl(sel,en,rspv,rdy) got %b want %b",
                         name, c, obs_ctl, exp_ctl);
            end

            obs_req = {bus.p_addr, bus.p_write, bus.p_wdata, bus.p_strb, bus.p_prot};
            n_cmp++;
            if (obs_req !== exp_req) begin
                n_bad++;
                $display("FAIL %s cyc%0d apb_req(addr,wr,wdata,strb,prot) got %h want %h",
                         name, c, obs_req, exp_req);
            end

            if (c >= 2 + len && c <= 2 + len + bp) begin
                obs_rsp = {bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout};
                n_cmp++;
                if (obs_rsp !== exp_rsp) begin
                    n_bad++;
                    $display("FAIL %s cyc%0d rsp(rdata,err,timeout) got %h want %h",
                             name, c, obs_rsp, exp_rsp);
                end
            end

            // Slave side; a timed-out slave answers late, in the first RESP cycle.
            rdy          = tmo ? (c == 2 + len) : (c == 1 + len);
            bus.p_ready  = rdy;
            bus.p_rdata  = rdy ? rdata : DW'($urandom);
            bus.p_slverr = rdy ? slverr : 1'($urandom);
            bus.rsp_rdy  = (c == 2 + len + bp);
            // A pending command during backpressure must not be accepted.
            bus.req_vld  = (bp > 0 && c >= 2 + len && c <= 2 + len + bp);

            if (c < last) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.req_vld   = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_strb  = '0;
        bus.req_prot  = '0;
        bus.p_ready   = 1'b0;
        bus.p_rdata   = '0;
        bus.p_slverr  = 1'b0;
        bus.rsp_rdy   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.req_rdy, bus.p_sel, bus.p_enable, bus.rsp_vld} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset ctl(rdy,sel,en,rspv) got %b want 1000",
                     {bus.req_rdy, bus.p_sel, bus.p_enable, bus.rsp_vld});
        end
        n_cmp++;
        if ({bus.p_addr, bus.p_write, bus.p_wdata, bus.p_strb, bus.p_prot,
             bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout} !== '0) begin
            n_bad++;
            $display("FAIL reset data outputs got %h want 0",
                     {bus.p_addr, bus.p_write, bus.p_wdata, bus.p_strb, bus.p_prot,
                      bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_basic;
        do_txn("write_basic", 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 3'b000, 0, 1'b0,
               32'hA5A5_5A5A, 0);
    endtask

    task automatic test_read_wait;
        do_txn("read_wait2", 1'b0, 16'h0004, 32'hFFFF_FFFF, 4'hF, 3'b010, 2, 1'b0,
               32'h12345678, 0);
    endtask

    task automatic test_slverr;
        do_txn("write_slverr", 1'b1, 16'h0020, 32'h0BAD_F00D, 4'h3, 3'b001, 1, 1'b1,
               32'h0, 0);
        do_txn("read_slverr", 1'b0, 16'h0024, 32'h0, 4'h0, 3'b000, 0, 1'b1,
               32'hCAFE_0001, 0);
    endtask

    task automatic test_timeout;
        do_txn("timeout_exact", 1'b0, 16'h0030, 32'h0, 4'h0, 3'b000, TO, 1'b0,
               32'h7777_7777, 0);
        do_txn("timeout_long", 1'b1, 16'h0034, 32'h1111_2222, 4'hC, 3'b100, 20, 1'b0,
               32'h0, 1);
        do_txn("ready_at_limit", 1'b0, 16'h0038, 32'h0, 4'h0, 3'b000, TO - 1, 1'b0,
               32'h3C3C_C3C3, 0);
    endtask

    task automatic test_backpressure;
        do_txn("backpressure", 1'b0, 16'h0040, 32'h0, 4'h0, 3'b011, 1, 1'b0,
               32'h5555_AAAA, 5);
    endtask

    task automatic test_back_to_back;
        do_txn("b2b_0", 1'b1, 16'h0100, 32'h0000_0001, 4'h1, 3'b000, 0, 1'b0, 32'h0, 0);
        do_txn("b2b_1", 1'b0, 16'h0104, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0000_0002, 0);
        do_txn("b2b_2", 1'b1, 16'h0108, 32'h0000_0003, 4'h8, 3'b111, 0, 1'b0, 32'h0, 0);
    endtask

    task automatic test_reset_mid;
        bus.req_vld   = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0050;
        bus.req_prot  = 3'b000;
        bus.p_ready   = 1'b0;
        @(posedge clk); #1;
        bus.req_vld = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.p_enable !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid access p_enable got %b want 1", bus.p_enable);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.p_sel, bus.p_enable, bus.rsp_vld, bus.req_rdy} !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_mid ctl(sel,en,rspv,rdy) got %b want 0001",
                     {bus.p_sel, bus.p_enable, bus.rsp_vld, bus.req_rdy});
        end
        n_cmp++;
        if (bus.p_addr !== '0) begin
            n_bad++;
            $display("FAIL reset_mid p_addr got %h want 0", bus.p_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.p_sel, bus.rsp_vld, bus.req_rdy} !== 3'b001) begin
            n_bad++;
            $display("FAIL reset_mid release ctl(sel,rspv,rdy) got %b want 001",
                     {bus.p_sel, bus.rsp_vld, bus.req_rdy});
        end
        do_txn("read_after_reset", 1'b0, 16'h0054, 32'h0, 4'h0, 3'b000, 1, 1'b0,
               32'hBEEF_0042, 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            do_txn($sformatf("rand%0d", i), 1'($urandom), AW'($urandom), DW'($urandom),
                   SW'($urandom), 3'($urandom), int'($urandom_range(0, 6)),
                   1'($urandom_range(0, 3) == 0), DW'($urandom),
                   int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset;
        test_write_basic;
        test_read_wait;
        test_slverr;
        test_timeout;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
